// File: rtl/multi_way_signal_ctrl.sv
// N-way traffic-signal controller: rotating green/yellow/all-red with demand skipping,
// emergency preemption and a flashing-yellow maintenance mode. All outputs registered.
module multi_way_signal_ctrl #(
    parameter int N_WAY    = 4,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int MIN_T    = 5,
    parameter int FLASH_T  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_WAY-1:0]           demand,
    input  logic                       emg_req,
    input  logic [$clog2(N_WAY)-1:0]   emg_way,
    output logic [3*N_WAY-1:0]         light,
    output logic [$clog2(N_WAY)-1:0]   active_way,
    output logic [1:0]                 phase
);

    localparam int WAY_W = $clog2(N_WAY);

    localparam logic [1:0] ALL_RED = 2'd0;
    localparam logic [1:0] GREEN   = 2'd1;
    localparam logic [1:0] YELLOW  = 2'd2;
    localparam logic [1:0] FLASH   = 2'd3;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] MIN_LD    = CNT_W'(MIN_T - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(N_WAY - 1);

    logic [CNT_W-1:0]   timer, nxt_timer;
    logic               flash_on, nxt_flash;
    logic               restart, nxt_restart;
    logic [1:0]         nxt_phase;
    logic [WAY_W-1:0]   nxt_way;
    logic [3*N_WAY-1:0] nxt_light;
    logic [WAY_W-1:0]   cyc_way, probe, found_way, next_way;
    logic               hit;
    logic               timer_done;

    assign timer_done = (timer == '0);

    // Scan active_way+1 upward with wrap; the last probe lands on active_way itself.
    always_comb begin
        cyc_way   = (active_way == LAST_WAY) ? '0 : active_way + WAY_W'(1);
        probe     = cyc_way;
        found_way = cyc_way;
        hit       = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (!hit && demand[probe]) begin
                found_way = probe;
                hit       = 1'b1;
            end
            probe = (probe == LAST_WAY) ? '0 : probe + WAY_W'(1);
        end
        if (emg_req)
            next_way = emg_way;
        else if (restart)
            next_way = '0;
        else
            next_way = found_way;
    end

    always_comb begin
        nxt_phase   = phase;
        nxt_way     = active_way;
        nxt_timer   = timer;
        nxt_flash   = flash_on;
        nxt_restart = restart;
        if (!enable) begin
            if (phase != FLASH) begin
                nxt_phase = FLASH;
                nxt_timer = FLASH_LD;
                nxt_flash = 1'b1;
            end else if (timer_done) begin
                nxt_flash = ~flash_on;
                nxt_timer = FLASH_LD;
            end else begin
                nxt_timer = timer - CNT_W'(1);
            end
        end else begin
            case (phase)
                FLASH: begin
                    nxt_phase   = ALL_RED;
                    nxt_timer   = ALLRED_LD;
                    nxt_restart = 1'b1;
                end
                ALL_RED: begin
                    if (timer_done) begin
                        nxt_phase   = GREEN;
                        nxt_way     = next_way;
                        nxt_timer   = GREEN_LD;
                        nxt_restart = 1'b0;
                    end else begin
                        nxt_timer = timer - CNT_W'(1);
                    end
                end
                GREEN: begin
                    // Holding for the emergency way keeps the timer parked so release gives MIN_T cycles.
                    if (emg_req && emg_way == active_way) begin
                        nxt_timer = MIN_LD;
                    end else if (emg_req || timer_done) begin
                        nxt_phase = YELLOW;
                        nxt_timer = YELLOW_LD;
                    end else begin
                        nxt_timer = timer - CNT_W'(1);
                    end
                end
                default: begin
                    if (timer_done) begin
                        nxt_phase = ALL_RED;
                        nxt_timer = ALLRED_LD;
                    end else begin
                        nxt_timer = timer - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        nxt_light = {N_WAY{3'b100}};
        for (int i = 0; i < N_WAY; i++) begin
            if (nxt_phase == FLASH)
                nxt_light[3*i +: 3] = nxt_flash ? 3'b010 : 3'b000;
            else if (i == int'(nxt_way) && nxt_phase == GREEN)
                nxt_light[3*i +: 3] = 3'b001;
            else if (i == int'(nxt_way) && nxt_phase == YELLOW)
                nxt_light[3*i +: 3] = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= ALL_RED;
            active_way <= '0;
            timer      <= ALLRED_LD;
            flash_on   <= 1'b0;
            restart    <= 1'b1;
            light      <= {N_WAY{3'b100}};
        end else begin
            phase      <= nxt_phase;
            active_way <= nxt_way;
            timer      <= nxt_timer;
            flash_on   <= nxt_flash;
            restart    <= nxt_restart;
            light      <= nxt_light;
        end
    end

endmodule

// File: tb/tb_multi_way_signal_ctrl.sv
// Scoreboard bench for multi_way_signal_ctrl: a cycle-count reference model predicts
// every registered output; a monitor on the falling edge compares against the DUT.
module tb_multi_way_signal_ctrl;

    localparam int N_WAY    = 4;
    localparam int GREEN_T  = 20;
    localparam int YELLOW_T = 4;
    localparam int ALLRED_T = 2;
    localparam int MIN_T    = 5;
    localparam int FLASH_T  = 8;
    localparam int WAY_W    = $clog2(N_WAY);

    localparam logic [1:0] P_AR     = 2'd0;
    localparam logic [1:0] P_GREEN  = 2'd1;
    localparam logic [1:0] P_YELLOW = 2'd2;
    localparam logic [1:0] P_FLASH  = 2'd3;

    typedef struct packed {
        logic [3*N_WAY-1:0] light;
        logic [WAY_W-1:0]   way;
        logic [1:0]         phase;
    } expect_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [N_WAY-1:0]     demand;
    logic                 emg_req;
    logic [WAY_W-1:0]     emg_way;
    logic [3*N_WAY-1:0]   light;
    logic [WAY_W-1:0]     active_way;
    logic [1:0]           phase;

    expect_t exp_q[$];
    int      checks   = 0;
    int      failures = 0;

    logic [1:0] m_phase   = P_AR;
    int         m_way     = 0;
    int         m_left    = 0;
    bit         m_lit     = 1'b0;
    bit         m_restart = 1'b0;
    bit         m_valid   = 1'b0;

    always #5 clk = ~clk;

    multi_way_signal_ctrl #(
        .N_WAY(N_WAY), .CNT_W(8), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
        .ALLRED_T(ALLRED_T), .MIN_T(MIN_T), .FLASH_T(FLASH_T)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .demand(demand),
        .emg_req(emg_req), .emg_way(emg_way), .light(light),
        .active_way(active_way), .phase(phase)
    );

    function automatic logic [3*N_WAY-1:0] lamp_model(input logic [1:0] p, input int w, input bit lit);
        logic [3*N_WAY-1:0] v;
        for (int i = 0; i < N_WAY; i++) begin
            if (p == P_FLASH)                   v[3*i +: 3] = lit ? 3'b010 : 3'b000;
            else if (i == w && p == P_GREEN)    v[3*i +: 3] = 3'b001;
            else if (i == w && p == P_YELLOW)   v[3*i +: 3] = 3'b010;
            else                                v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    function automatic int pick_next(input int way, input logic [N_WAY-1:0] dem,
                                     input bit emg, input int ew, input bit rs);
        if (emg) return ew;
        if (rs) return 0;
        for (int k = 1; k <= N_WAY; k++)
            if (dem[(way + k) % N_WAY]) return (way + k) % N_WAY;
        return (way + 1) % N_WAY;
    endfunction

    // Reference model: each state is tracked as the number of cycles it still has to run.
    always @(posedge clk) begin : model
        logic [1:0] p;
        int         w, l;
        bit         lit, rs;
        expect_t    e;
        p = m_phase; w = m_way; l = m_left; lit = m_lit; rs = m_restart;
        if (reset) begin
            p = P_AR; w = 0; l = ALLRED_T; lit = 1'b0; rs = 1'b1;
        end else if (!enable) begin
            if (p != P_FLASH) begin
                p = P_FLASH; l = FLASH_T; lit = 1'b1;
            end else if (l == 1) begin
                lit = !lit; l = FLASH_T;
            end else begin
                l = l - 1;
            end
        end else begin
            case (p)
                P_FLASH: begin p = P_AR; l = ALLRED_T; rs = 1'b1; end
                P_AR: begin
                    if (l == 1) begin
                        w = pick_next(w, demand, emg_req, int'(emg_way), rs);
                        p = P_GREEN; l = GREEN_T; rs = 1'b0;
                    end else l = l - 1;
                end
                P_GREEN: begin
                    if (emg_req && int'(emg_way) == w) l = MIN_T;
                    else if (emg_req || l == 1) begin p = P_YELLOW; l = YELLOW_T; end
                    else l = l - 1;
                end
                default: begin
                    if (l == 1) begin p = P_AR; l = ALLRED_T; end
                    else l = l - 1;
                end
            endcase
        end
        m_phase <= p; m_way <= w; m_left <= l; m_lit <= lit; m_restart <= rs;
        if (reset) m_valid <= 1'b1;
        if (reset || m_valid) begin
            e.light = lamp_model(p, w, lit);
            e.way   = WAY_W'(w);
            e.phase = p;
            exp_q.push_back(e);
        end
    end

    task automatic checkOutput(input expect_t e);
        int nonred;
        checks++;
        if (light !== e.light || active_way !== e.way || phase !== e.phase) begin
            failures++;
            $display("[TB] FAIL state @%0t: light=%h exp %h way=%0d exp %0d phase=%0d exp %0d",
                     $time, light, e.light, active_way, e.way, phase, e.phase);
        end
        if (e.phase != P_FLASH) begin
            nonred = 0;
            for (int i = 0; i < N_WAY; i++)
                if (light[3*i +: 3] !== 3'b100) nonred++;
            checks++;
            if (nonred > 1) begin
                failures++;
                $display("[TB] FAIL one_non_red @%0t: non-red ways=%0d, required <=1", $time, nonred);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic applyStimulus(input bit r, input bit en, input logic [N_WAY-1:0] dem,
                                 input bit emg, input int ew, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            reset   = r;
            enable  = en;
            demand  = dem;
            emg_req = emg;
            emg_way = WAY_W'(ew);
            @(negedge clk);
        end
    endtask

    task automatic waitFor(input logic [1:0] p, input int w, input int budget);
        int c;
        c = 0;
        while (!(m_phase == p && m_way == w) && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!(m_phase == p && m_way == w)) begin
            failures++;
            $display("[TB] FAIL wait_timeout: phase=%0d way=%0d, required phase=%0d way=%0d",
                     m_phase, m_way, p, w);
        end
    endtask

    initial begin : driver
        logic [N_WAY-1:0] rdem;
        int               len;
        bit               ren, remg, rrst;

        applyStimulus(1, 1, '0, 0, 0, 3);
        $display("[TB] cyclic rotation from reset");
        applyStimulus(0, 1, '0, 0, 0, 26 * 5 + 2);

        $display("[TB] demand skip to way 2");
        waitFor(P_GREEN, 0, 200);
        applyStimulus(0, 1, 4'b0100, 0, 0, 50);
        applyStimulus(0, 1, '0, 0, 0, 10);

        $display("[TB] emergency preemption to way 3");
        waitFor(P_GREEN, 0, 200);
        applyStimulus(0, 1, '0, 0, 0, 5);
        applyStimulus(0, 1, '0, 1, 3, 30);
        applyStimulus(0, 1, '0, 0, 3, 30);

        $display("[TB] maintenance flash and restart");
        waitFor(P_GREEN, 1, 200);
        applyStimulus(0, 1, '0, 0, 0, 7);
        applyStimulus(0, 0, 4'b1111, 1, 2, 30);
        applyStimulus(0, 1, '0, 0, 0, 30);

        $display("[TB] reset during yellow on way 2");
        waitFor(P_YELLOW, 2, 300);
        applyStimulus(0, 1, '0, 0, 0, 1);
        applyStimulus(1, 1, '0, 0, 0, 1);
        applyStimulus(0, 1, '0, 0, 0, 30);

        $display("[TB] randomized traffic");
        for (int b = 0; b < 80; b++) begin
            rrst = ($urandom_range(0, 24) == 0);
            ren  = ($urandom_range(0, 9) != 0);
            remg = ($urandom_range(0, 3) == 0);
            rdem = N_WAY'($urandom);
            if ($urandom_range(0, 2) == 0) rdem = '0;
            len  = rrst ? 1 : int'($urandom_range(5, 40));
            applyStimulus(rrst, ren, rdem, remg, int'($urandom_range(0, N_WAY - 1)), len);
        end
        applyStimulus(0, 1, '0, 0, 0, 5);

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
